alu_decoder_registers: RTL and testbench

ALU_DECODER_REGISTERS -- requirements
Module: alu_decoder_registers

---
 rtl/alu_decoder_registers_pkg.sv | 61 ++++++
 rtl/alu_decoder_registers_alu.sv | 122 ++++++++++++
 rtl/alu_decoder_registers_decoder.sv | 24 ++
 rtl/alu_decoder_registers_regfile.sv | 43 ++++
 rtl/alu_decoder_registers.sv | 72 +++++++
 tb/tb_alu_decoder_registers.sv | 184 ++++++++++++++++++
 6 files changed

// File: rtl/alu_decoder_registers_pkg.sv
// Shared constants for the decoder / register file / ALU slice.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package alu_decoder_registers_pkg;

  // Flag vector layout (alu_flags[5:0]); bit 5 is reserved and always 0.
  localparam int FLAG_W = 6;
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_P = 4;

  // Instruction group field (word[15:12]); consumed by the sequencer.
  localparam logic [3:0] GRP_ALU2   = 4'h1;
  localparam logic [3:0] GRP_ALU1   = 4'h2;
  localparam logic [3:0] GRP_LDI    = 4'h3;
  localparam logic [3:0] GRP_BRANCH = 4'h4;
  localparam logic [3:0] GRP_MOVE   = 4'h5;

  // Two-operand ALU operators (alu_single = 0).
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_CMP = 4'd5, ALU_ADC = 4'd6, ALU_SBC = 4'd7
  } alu2_op_e;

  // Single-operand ALU operators (alu_single = 1).
  typedef enum logic [3:0] {
    ALU_INC = 4'd0, ALU_DEC = 4'd1, ALU_NOT = 4'd2, ALU_NEG = 4'd3,
    ALU_SHL = 4'd4, ALU_SHR = 4'd5, ALU_ROL = 4'd6, ALU_ROR = 4'd7
  } alu1_op_e;

  // Branch conditions, selected by the operator field.
  typedef enum logic [3:0] {
    BR_NEVER = 4'd0, BR_Z  = 4'd1, BR_NZ = 4'd2, BR_C    = 4'd3,
    BR_NC    = 4'd4, BR_N  = 4'd5, BR_NN = 4'd6, BR_V    = 4'd7,
    BR_NV    = 4'd8, BR_CZ = 4'd9, BR_NCNZ = 4'd10
  } br_cond_e;

  // Evaluate a branch condition against a flag vector; codes 11-15 never take.
  function automatic logic branch_taken(input logic [3:0] cond,
                                        input logic [FLAG_W-1:0] fl);
    logic t;
    t = 1'b0;
    case (cond)
      BR_Z:    t = fl[FLAG_Z];
      BR_NZ:   t = ~fl[FLAG_Z];
      BR_C:    t = fl[FLAG_C];
      BR_NC:   t = ~fl[FLAG_C];
      BR_N:    t = fl[FLAG_N];
      BR_NN:   t = ~fl[FLAG_N];
      BR_V:    t = fl[FLAG_V];
      BR_NV:   t = ~fl[FLAG_V];
      BR_CZ:   t = fl[FLAG_C] | fl[FLAG_Z];
      BR_NCNZ: t = ~fl[FLAG_C] & ~fl[FLAG_Z];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/alu_decoder_registers_alu.sv
// Registered ALU: two-operand and single-operand ops with C/Z/N/V/P flags.
// Latency: 1 cycle, result and flags captured every posedge; async active-low reset clears both.
// Backpressure: none. Ports: single_i, op_i, a_i, b_i -> out_o, flags_o.
module alu_decoder_registers_alu
  import alu_decoder_registers_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              single_i,
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] out_o,
  output logic [FLAG_W-1:0] flags_o
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] out_q, out_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  logic [DATA_W:0]   wide;     // DATA_W+1 bits: top bit is carry/borrow
  logic [DATA_W-1:0] fres;     // value the Z/N/P flags are computed from
  logic              c_n, v_n, upd, cin;

  function automatic logic add_ovf(input logic [DATA_W-1:0] a, b, r);
    return (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
  endfunction

  function automatic logic sub_ovf(input logic [DATA_W-1:0] a, b, r);
    return (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
  endfunction

  always_comb begin
    out_d = a_i;
    fres  = a_i;
    wide  = '0;
    c_n   = 1'b0;
    v_n   = 1'b0;
    upd   = 1'b1;
    cin   = flags_q[FLAG_C];
    if (!single_i) begin
      case (op_i)
        ALU_ADD, ALU_ADC: begin
          wide  = {1'b0, a_i} + {1'b0, b_i}
                + {{DATA_W{1'b0}}, (op_i == ALU_ADC) & cin};
          out_d = wide[MSB:0];
          c_n   = wide[DATA_W];
          v_n   = add_ovf(a_i, b_i, wide[MSB:0]);
        end
        ALU_SUB, ALU_SBC, ALU_CMP: begin
          // Borrow falls out as the top bit of the widened difference.
          wide  = {1'b0, a_i} - {1'b0, b_i}
                - {{DATA_W{1'b0}}, (op_i == ALU_SBC) & cin};
          out_d = (op_i == ALU_CMP) ? a_i : wide[MSB:0];
          c_n   = wide[DATA_W];
          v_n   = sub_ovf(a_i, b_i, wide[MSB:0]);
        end
        ALU_AND: out_d = a_i & b_i;
        ALU_OR:  out_d = a_i | b_i;
        ALU_XOR: out_d = a_i ^ b_i;
        default: upd = 1'b0;
      endcase
      // CMP keeps v1 as its result but flags the difference.
      fres = (op_i == ALU_CMP) ? wide[MSB:0] : out_d;
    end else begin
      case (op_i)
        ALU_INC: begin
          wide  = {1'b0, a_i} + {{DATA_W{1'b0}}, 1'b1};
          out_d = wide[MSB:0];
          c_n   = wide[DATA_W];
          v_n   = add_ovf(a_i, {{MSB{1'b0}}, 1'b1}, wide[MSB:0]);
        end
        ALU_DEC: begin
          wide  = {1'b0, a_i} - {{DATA_W{1'b0}}, 1'b1};
          out_d = wide[MSB:0];
          c_n   = wide[DATA_W];
          v_n   = sub_ovf(a_i, {{MSB{1'b0}}, 1'b1}, wide[MSB:0]);
        end
        ALU_NOT: out_d = ~a_i;
        ALU_NEG: begin
          wide  = {(DATA_W+1){1'b0}} - {1'b0, a_i};
          out_d = wide[MSB:0];
          c_n   = wide[DATA_W];
          v_n   = sub_ovf('0, a_i, wide[MSB:0]);
        end
        ALU_SHL: begin out_d = {a_i[MSB-1:0], 1'b0}; c_n = a_i[MSB]; end
        ALU_SHR: begin out_d = {1'b0, a_i[MSB:1]};   c_n = a_i[0];   end
        ALU_ROL: begin out_d = {a_i[MSB-1:0], cin};  c_n = a_i[MSB]; end
        ALU_ROR: begin out_d = {cin, a_i[MSB:1]};    c_n = a_i[0];   end
        default: upd = 1'b0;
      endcase
      fres = out_d;
    end

    flags_d = flags_q;
    if (upd) begin
      flags_d         = '0;
      flags_d[FLAG_C] = c_n;
      flags_d[FLAG_Z] = (fres == '0);
      flags_d[FLAG_N] = fres[MSB];
      flags_d[FLAG_V] = v_n;
      flags_d[FLAG_P] = ~^fres;   // set when the result has an even number of ones
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign out_o   = out_q;
  assign flags_o = flags_q;

endmodule

// File: rtl/alu_decoder_registers_decoder.sv
// Instruction field decoder: slices a 16-bit word into its fields.
// Latency: purely combinational, no state, unaffected by reset.
// Backpressure: none. Ports: word_i -> group/operator/register/immediate/offset fields.
module alu_decoder_registers_decoder (
  input  logic [15:0] word_i,
  output logic [3:0]  operator_group_o,
  output logic [3:0]  operator_o,
  output logic [2:0]  rgv_o,
  output logic [2:0]  rg1_o,
  output logic [2:0]  rg2_o,
  output logic [7:0]  val_o,
  output logic [9:0]  relative_addr_o
);

  // Fields overlap on purpose: each instruction group uses a different subset.
  assign operator_group_o = word_i[15:12];
  assign operator_o       = word_i[11:8];
  assign rgv_o            = word_i[10:8];
  assign val_o            = word_i[7:0];
  assign rg2_o            = word_i[5:3];
  assign rg1_o            = word_i[2:0];
  assign relative_addr_o  = word_i[9:0];

endmodule

// File: rtl/alu_decoder_registers_regfile.sv
// General register file: NREGS x DATA_W, one write-data port with two write enables, two read ports.
// Latency: reads combinational; writes land at posedge clk. Async active-low reset clears all.
// Backpressure: none. Ports: clk, reset, we_i[1:0], widx1_i/widx2_i, wdat_i, ridx1_i/ridx2_i -> rdat1_o/rdat2_o.
module alu_decoder_registers_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 4,
  parameter int IDX_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        we_i,
  input  logic [IDX_W-1:0]  widx1_i,
  input  logic [IDX_W-1:0]  widx2_i,
  input  logic [DATA_W-1:0] wdat_i,
  input  logic [IDX_W-1:0]  ridx1_i,
  input  logic [IDX_W-1:0]  ridx2_i,
  output logic [DATA_W-1:0] rdat1_o,
  output logic [DATA_W-1:0] rdat2_o
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Both enables carry the same data, so a double write to one index is
  // indistinguishable from a single write.
  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (we_i[0]) regs_d[widx1_i] = wdat_i;
    if (we_i[1]) regs_d[widx2_i] = wdat_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign rdat1_o = regs_q[ridx1_i];
  assign rdat2_o = regs_q[ridx2_i];

endmodule

// File: rtl/alu_decoder_registers.sv
// Decoder + 4x16 register file + registered ALU, with branch-condition evaluation.
// Latency: decode/reg read/check_branch combinational; ALU result and flags 1 cycle; writes at posedge.
// Backpressure: none. Ports: clk, reset (async, active-low), word, reg_write/reg_in, alu_single/alu_value1/alu_value2
//   -> decoded fields, reg_out1/reg_out2, alu_out, alu_flags, check_branch.
module alu_decoder_registers
  import alu_decoder_registers_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       word,
  output logic [3:0]        operator_group,
  output logic [3:0]        operator,
  output logic [2:0]        rgv,
  output logic [2:0]        rg1,
  output logic [2:0]        rg2,
  output logic [7:0]        val,
  output logic [9:0]        relative_addr,
  input  logic [1:0]        reg_write,
  input  logic [DATA_W-1:0] reg_in,
  output logic [DATA_W-1:0] reg_out1,
  output logic [DATA_W-1:0] reg_out2,
  input  logic              alu_single,
  input  logic [DATA_W-1:0] alu_value1,
  input  logic [DATA_W-1:0] alu_value2,
  output logic [DATA_W-1:0] alu_out,
  output logic [FLAG_W-1:0] alu_flags,
  output logic              check_branch
);

  alu_decoder_registers_decoder u_dec (
    .word_i           (word),
    .operator_group_o (operator_group),
    .operator_o       (operator),
    .rgv_o            (rgv),
    .rg1_o            (rg1),
    .rg2_o            (rg2),
    .val_o            (val),
    .relative_addr_o  (relative_addr)
  );

  // Register fields are 3 bits; the upper two select one of the four registers.
  alu_decoder_registers_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .IDX_W(2)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (reg_write),
    .widx1_i (rg1[2:1]),
    .widx2_i (rg2[2:1]),
    .wdat_i  (reg_in),
    .ridx1_i (rg1[2:1]),
    .ridx2_i (rg2[2:1]),
    .rdat1_o (reg_out1),
    .rdat2_o (reg_out2)
  );

  alu_decoder_registers_alu #(.DATA_W(DATA_W)) u_alu (
    .clk      (clk),
    .reset    (reset),
    .single_i (alu_single),
    .op_i     (operator),
    .a_i      (alu_value1),
    .b_i      (alu_value2),
    .out_o    (alu_out),
    .flags_o  (alu_flags)
  );

  // Condition is the current operator field tested against the flags of the last capture.
  assign check_branch = branch_taken(operator, alu_flags);

endmodule

// File: tb/tb_alu_decoder_registers.sv
module tb_alu_decoder_registers;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] word;
  logic [3:0]  operator_group, operator;
  logic [2:0]  rgv, rg1, rg2;
  logic [7:0]  val;
  logic [9:0]  relative_addr;
  logic [1:0]  reg_write;
  logic [15:0] reg_in, reg_out1, reg_out2;
  logic        alu_single;
  logic [15:0] alu_value1, alu_value2, alu_out;
  logic [5:0]  alu_flags;
  logic        check_branch;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_decoder_registers dut (
    .clk            (clk),
    .reset          (reset),
    .word           (word),
    .operator_group (operator_group),
    .operator       (operator),
    .rgv            (rgv),
    .rg1            (rg1),
    .rg2            (rg2),
    .val            (val),
    .relative_addr  (relative_addr),
    .reg_write      (reg_write),
    .reg_in         (reg_in),
    .reg_out1       (reg_out1),
    .reg_out2       (reg_out2),
    .alu_single     (alu_single),
    .alu_value1     (alu_value1),
    .alu_value2     (alu_value2),
    .alu_out        (alu_out),
    .alu_flags      (alu_flags),
    .check_branch   (check_branch)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one ALU op through a clock edge, then compare result and flags.
  task automatic alu_op(input string tag, input logic single, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_out, input logic [5:0] exp_fl);
    alu_single = single;
    word       = {4'h1, op, 8'h00};
    alu_value1 = a;
    alu_value2 = b;
    tick();
    check({tag, "_out"}, 32'(alu_out), 32'(exp_out));
    check({tag, "_flags"}, 32'(alu_flags), 32'(exp_fl));
  endtask

  task automatic branch(input string tag, input logic [3:0] op, input logic exp);
    word = {4'h4, op, 8'h00};
    #1;
    check(tag, 32'(check_branch), 32'(exp));
  endtask

  // Flags are {0, P, V, N, Z, C}.
  initial begin
    reset = 1'b1; word = 16'h0000; reg_write = 2'b00; reg_in = 16'h0000;
    alu_single = 1'b0; alu_value1 = 16'h0000; alu_value2 = 16'h0000;
    #1 reset = 1'b0;
    #1;
    check("rst_alu_out", 32'(alu_out), 32'h0);
    check("rst_flags", 32'(alu_flags), 32'h0);
    check("rst_reg_out1", 32'(reg_out1), 32'h0);
    check("rst_reg_out2", 32'(reg_out2), 32'h0);
    // Captures and writes during reset are discarded.
    word = 16'h0000; alu_value1 = 16'h1111; alu_value2 = 16'h2222; reg_write = 2'b01; reg_in = 16'hDEAD;
    tick();
    check("rst_hold_alu", 32'(alu_out), 32'h0);
    check("rst_hold_reg", 32'(reg_out1), 32'h0);
    reg_write = 2'b00;
    reset = 1'b1;

    // Decoder.
    word = 16'hA5C3; #1;
    check("dec_group", 32'(operator_group), 32'hA);
    check("dec_operator", 32'(operator), 32'h5);
    check("dec_rgv", 32'(rgv), 32'h5);
    check("dec_val", 32'(val), 32'hC3);
    check("dec_rg2", 32'(rg2), 32'h0);
    check("dec_rg1", 32'(rg1), 32'h3);
    check("dec_rel", 32'(relative_addr), 32'h1C3);

    // Register file: write idx1 via rg1, read via rg2.
    word = 16'h0002; reg_write = 2'b01; reg_in = 16'h1234;
    tick();
    reg_write = 2'b00; word = 16'h0010; #1;
    check("rf_rd_idx1", 32'(reg_out2), 32'h1234);
    // Both enables, same index 2.
    word = 16'h0024; reg_write = 2'b11; reg_in = 16'hBEEF;
    tick();
    // Both enables, different indices 3 and 0.
    word = 16'h0006; reg_write = 2'b11; reg_in = 16'hCAFE;
    tick();
    reg_write = 2'b00; #1;
    check("rf_dual_idx3", 32'(reg_out1), 32'hCAFE);
    check("rf_dual_idx0", 32'(reg_out2), 32'hCAFE);
    word = 16'h0014; #1;
    check("rf_same_idx2", 32'(reg_out1), 32'hBEEF);
    check("rf_keep_idx1", 32'(reg_out2), 32'h1234);

    // ALU two-operand.
    alu_op("add", 1'b0, 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 6'h13);
    branch("br_z", 4'd1, 1'b1);
    branch("br_nz", 4'd2, 1'b0);
    branch("br_cz", 4'd9, 1'b1);
    branch("br_11", 4'd11, 1'b0);
    alu_op("adc", 1'b0, 4'd6, 16'h0001, 16'h0001, 16'h0003, 6'h10);
    alu_op("sub", 1'b0, 4'd1, 16'h7FFF, 16'hFFFF, 16'h8000, 6'h0D);
    branch("br_v", 4'd7, 1'b1);
    branch("br_nv", 4'd8, 1'b0);
    branch("br_n", 4'd5, 1'b1);
    alu_op("cmp", 1'b0, 4'd5, 16'h0005, 16'h0005, 16'h0005, 6'h12);
    alu_op("sub_borrow", 1'b0, 4'd1, 16'h0000, 16'h0001, 16'hFFFF, 6'h15);
    alu_op("sbc", 1'b0, 4'd7, 16'h0005, 16'h0002, 16'h0002, 6'h00);
    branch("br_ncnz", 4'd10, 1'b1);
    alu_op("xor", 1'b0, 4'd4, 16'hAAAA, 16'hFFFF, 16'h5555, 6'h10);
    alu_op("pass2", 1'b0, 4'd9, 16'h1357, 16'h0000, 16'h1357, 6'h10);

    // ALU single-operand.
    alu_op("inc", 1'b1, 4'd0, 16'h7FFF, 16'h0000, 16'h8000, 6'h0C);
    alu_op("dec", 1'b1, 4'd1, 16'h0000, 16'h0000, 16'hFFFF, 6'h15);
    alu_op("neg", 1'b1, 4'd3, 16'h8000, 16'h0000, 16'h8000, 6'h0D);
    alu_op("not", 1'b1, 4'd2, 16'h00FF, 16'h0000, 16'hFF00, 6'h14);
    alu_op("shr", 1'b1, 4'd5, 16'h0003, 16'h0000, 16'h0001, 6'h01);
    alu_op("and", 1'b0, 4'd2, 16'hFFFF, 16'h0F0F, 16'h0F0F, 6'h10);
    alu_op("rol", 1'b1, 4'd6, 16'h8000, 16'h0000, 16'h0000, 6'h13);
    alu_op("ror", 1'b1, 4'd7, 16'h0002, 16'h0000, 16'h8001, 6'h14);
    alu_op("shl", 1'b1, 4'd4, 16'h4001, 16'h0000, 16'h8002, 6'h14);
    alu_op("pass1", 1'b1, 4'd12, 16'h2468, 16'h0000, 16'h2468, 6'h14);

    // Mid-cycle asynchronous reset after a write and a capture.
    word = 16'h0000; reg_write = 2'b01; reg_in = 16'h5A5A;
    alu_single = 1'b0; alu_value1 = 16'h0001; alu_value2 = 16'h0001;
    tick();
    reg_write = 2'b00;
    check("pre_rst_reg0", 32'(reg_out1), 32'h5A5A);
    check("pre_rst_alu", 32'(alu_out), 32'h0002);
    #2 reset = 1'b0;
    #1;
    check("async_alu_out", 32'(alu_out), 32'h0);
    check("async_flags", 32'(alu_flags), 32'h0);
    for (int i = 0; i < 4; i++) begin
      word = 16'((i * 2) << 3) | 16'(i * 2);
      #1;
      check($sformatf("async_reg%0d_p1", i), 32'(reg_out1), 32'h0);
      check($sformatf("async_reg%0d_p2", i), 32'(reg_out2), 32'h0);
    end
    tick();
    reset = 1'b1;
    word = 16'h0010; #1;
    check("rst_pulse_idx1", 32'(reg_out2), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
